button_pio_debounced: RTL and testbench

//  Parametrised Avalon-MM input PIO for push buttons/switches: WIDTH channels, 2-flop sync,
//  per-channel counter debounce, selectable edge detection, per-bit edge capture, masked IRQ.

---
 rtl/button_pio_debounced_pkg.sv | 29 ++
 rtl/button_pio_debounced_if.sv | 19 +
 rtl/button_pio_debounced_debounce_ch.sv | 51 +++++
 rtl/button_pio_debounced.sv | 91 +++++++++
 tb/tb_button_pio_debounced.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/button_pio_debounced_pkg.sv
// Shared definitions for the debounced button PIO: register map, edge modes,
// and the rule that turns a channel's rise/fall pulses into a capture event.
package button_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        MODE_FALL = 2'b00,
        MODE_RISE = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    function automatic logic edge_qualify(input mode_e mode, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_FALL: hit = fall;
            MODE_RISE: hit = rise;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/button_pio_debounced_if.sv
// Avalon-MM slave bus of the button PIO, including its level interrupt line.
interface button_pio_debounced_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );
endinterface

// File: rtl/button_pio_debounced_debounce_ch.sv
// One input channel: two-flop synchroniser, stability counter, debounced level,
// and single-cycle rise/fall pulses asserted in the cycle the level is accepted.
module debounce_ch #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter logic        RESET_BIT  = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic          deb_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    // New level is taken on the DEB_CYCLES-th consecutive cycle of disagreement.
    assign accept = (s2_reg != deb_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg  <= RESET_BIT;
            s2_reg  <= RESET_BIT;
            deb_reg <= RESET_BIT;
            cnt_reg <= '0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
            if (s2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                deb_reg <= s2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign deb  = deb_reg;
    assign rise = accept &  s2_reg;
    assign fall = accept & ~s2_reg;

endmodule

// File: rtl/button_pio_debounced.sv
// Debounced push-button input PIO on Avalon-MM: per-channel debounce, selectable
// edge detection, write-one-to-clear edge capture and a masked level interrupt.
module button_pio_debounced
    import button_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      DEB_CYCLES  = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in_port,
    button_pio_debounced_if.slave  bus
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_vec;

    mode_e            mode_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] clear_vec;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             wr_en;
    logic             unused_wdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            debounce_ch #(
                .DEB_CYCLES (DEB_CYCLES),
                .RESET_BIT  (RESET_LEVEL[gi])
            ) u_ch (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (in_port[gi]),
                .deb     (deb[gi]),
                .rise    (rise[gi]),
                .fall    (fall[gi])
            );
            assign edge_vec[gi] = edge_qualify(mode_reg, rise[gi], fall[gi]);
        end
    endgenerate

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // Clear is applied before set so an edge arriving with its own W1C is kept.
    always_comb begin
        clear_vec = '0;
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            clear_vec = bus.writedata[WIDTH-1:0];
        end
        edge_cap_next = (edge_cap_reg & ~clear_vec) | edge_vec;
    end

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA:    readdata_next[WIDTH-1:0] = deb;
            ADDR_MODE:    readdata_next[1:0]       = mode_reg;
            ADDR_IRQMASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            default:      readdata_next[WIDTH-1:0] = edge_cap_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg     <= MODE_FALL;
            irq_mask_reg <= '0;
            edge_cap_reg <= '0;
            readdata_reg <= '0;
        end else begin
            edge_cap_reg <= edge_cap_next;
            readdata_reg <= readdata_next;
            if (wr_en && (bus.address == ADDR_MODE)) begin
                mode_reg <= mode_e'(bus.writedata[1:0]);
            end
            if (wr_en && (bus.address == ADDR_IRQMASK)) begin
                irq_mask_reg <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Directed plus randomized bench for button_pio_debounced with a cycle-level
// behavioural model of the register file and debounce rules.
module tb_button_pio_debounced;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;

    button_pio_debounced_if bif ();

    button_pio_debounced #(
        .WIDTH       (WIDTH),
        .DEB_CYCLES  (DEB),
        .RESET_LEVEL (4'hF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_s1, m_s2, m_deb, m_mask, m_cap;
    logic [1:0]       m_mode;
    logic [31:0]      m_rd;
    int               m_run [WIDTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF;
        m_mask = '0; m_cap = '0; m_mode = 2'b00; m_rd = '0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    endtask

    task automatic tick();
        logic             wr;
        logic [WIDTH-1:0] ev;
        logic [31:0]      rd_n;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            wr = bif.chipselect && !bif.write_n;
            case (bif.address)
                2'd0:    rd_n = {28'b0, m_deb};
                2'd1:    rd_n = {30'b0, m_mode};
                2'd2:    rd_n = {28'b0, m_mask};
                default: rd_n = {28'b0, m_cap};
            endcase
            ev = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_mode == 2'b10) ev[i] = 1'b1;
                        else if (m_mode == 2'b01) ev[i] = m_deb[i];
                        else if (m_mode == 2'b00) ev[i] = !m_deb[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_port;
            if (wr && bif.address == 2'd3) m_cap = m_cap & ~bif.writedata[3:0];
            m_cap = m_cap | ev;
            if (wr && bif.address == 2'd1) m_mode = bif.writedata[1:0];
            if (wr && bif.address == 2'd2) m_mask = bif.writedata[3:0];
            m_rd = rd_n;
        end
        #1;
        check("readdata", bif.readdata, m_rd);
        check("irq", {31'b0, bif.irq}, {31'b0, |(m_cap & m_mask)});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bif.address = a; bif.writedata = d;
        bif.chipselect = 1'b1; bif.write_n = 1'b0;
        tick();
        bif.chipselect = 1'b0; bif.write_n = 1'b1;
        $display("WR addr=%0d data=%08h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bif.address = a;
        tick();
        check(tag, bif.readdata, exp);
        $display("RD addr=%0d data=%08h expect=%08h", a, bif.readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; in_port = 4'hF;
        bif.address = 2'd0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = '0;
        model_reset();
        #3;
        check("rst_readdata", bif.readdata, 32'h0);
        check("rst_irq", {31'b0, bif.irq}, 32'h0);
        ticks(3);
        reset_n = 1'b1;

        bus_read(2'd0, 32'hF, "rst_data");
        bus_read(2'd1, 32'h0, "rst_mode");
        bus_read(2'd2, 32'h0, "rst_mask");
        bus_read(2'd3, 32'h0, "rst_edgecap");

        // Press bit0: DATA changes on the 10th edge, visible on readdata one edge later.
        bif.address = 2'd0;
        in_port[0] = 1'b0;
        ticks(10);
        check("press_not_yet", bif.readdata, 32'hF);
        tick();
        check("press_data", bif.readdata, 32'hE);
        bus_read(2'd3, 32'h1, "press_edgecap");
        bus_write(2'd2, 32'h1);
        check("irq_masked_on", {31'b0, bif.irq}, 32'h1);

        // Bounce on bit1 shorter than the debounce window.
        in_port[1] = 1'b0;
        ticks(7);
        in_port[1] = 1'b1;
        ticks(12);
        bus_read(2'd0, 32'hE, "bounce_data");
        bus_read(2'd3, 32'h1, "bounce_edgecap");

        // Real press on bit1, then W1C bit0.
        in_port[1] = 1'b0;
        ticks(12);
        bus_read(2'd3, 32'h3, "edgecap_two");
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h2, "w1c_bit0");
        check("irq_after_clear", {31'b0, bif.irq}, 32'h0);
        bus_write(2'd2, 32'h2);
        check("irq_mask_bit1", {31'b0, bif.irq}, 32'h1);

        // Rising mode on release, then none.
        bus_write(2'd1, 32'h1);
        in_port[0] = 1'b1;
        ticks(12);
        bus_read(2'd3, 32'h3, "rise_capture");
        bus_write(2'd1, 32'h3);
        bus_write(2'd3, 32'h1);
        in_port[0] = 1'b0;
        ticks(12);
        in_port[0] = 1'b1;
        ticks(12);
        bus_read(2'd3, 32'h2, "none_no_capture");

        // W1C of bit2 landing on the same edge bit2 is captured.
        bus_write(2'd1, 32'h0);
        in_port[2] = 1'b0;
        ticks(9);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, 32'h6, "w1c_race_set_wins");

        // Reset while bit3 is bouncing.
        in_port[3] = 1'b0;
        ticks(5);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_readdata", bif.readdata, 32'h0);
        check("midreset_irq", {31'b0, bif.irq}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        bus_read(2'd0, 32'hF, "midreset_data");
        bus_read(2'd3, 32'h0, "midreset_edgecap");
        ticks(12);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                in_port = in_port ^ 4'($urandom_range(1, 15));
                ticks($urandom_range(1, 12));
            end else if (r < 8) begin
                bus_write(2'($urandom_range(1, 3)), $urandom);
            end else begin
                bif.address = 2'($urandom_range(0, 3));
                tick();
            end
        end
        ticks(15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
